// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the data-memory load/store unit.
//   - funct3 size/sign codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding
//   - req_bad(): flags illegal funct3 codes and misaligned addresses
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Returns 1 when the request cannot be serviced: unknown funct3, an
  // unsigned-size code on a store, or a halfword/word that is misaligned.
  function automatic logic req_bad(input logic       we,
                                   input logic [2:0] funct3,
                                   input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational data steering for dmem_lsu.
//   funct3     in  : latched size/sign code
//   addr_lo    in  : latched byte offset within the word
//   rdata      in  : word read from memory
//   wdata_lo   in  : low 16 bits of the right-aligned store data
//   merge      in  : word captured during the read phase of a read-modify-write
//   load_data  out : selected byte/halfword/word, sign- or zero-extended
//   store_data out : merge word with the addressed byte/halfword lane replaced
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata_lo,
  input  logic [31:0] merge,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  // Bring the addressed lane down to bit 0 (little-endian lanes).
  logic [31:0] shifted;
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

  // Per-lane merge: a byte store hits exactly one lane, a halfword store
  // hits the pair selected by addr_lo[1] and feeds each lane its own byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = ((funct3 == F3_B) && (addr_lo == 2'(gi))) ||
                   ((funct3 == F3_H) && (addr_lo[1] == 1'(gi / 2)));
      assign src = (funct3 == F3_H) ? wdata_lo[8*(gi%2) +: 8] : wdata_lo[7:0];
      assign store_data[8*gi +: 8] = hit ? src : merge[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the MEM stage and a word-wide data memory
// with combinational read and synchronous word write.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,
//   req_wdata                        : request fields, latched on acceptance
//   resp_valid, resp_err, resp_rdata : one-cycle completion pulse and result
//   mem_wen, mem_addr, mem_wdata     : memory write port / word address
//   mem_rdata                        : combinational memory read data
// Loads, word stores and rejected requests respond one cycle after
// acceptance; byte/halfword stores take a read cycle then a write cycle.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      merge_q, merge_d;

  logic [WIDTH-1:0]      load_data;
  logic [WIDTH-1:0]      store_data;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata_lo   (wdata_q[15:0]),
    .merge      (merge_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Next state and request latching.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_bad(req_we, req_funct3, req_addr[1:0])) state_d = ST_ERR;
          else if (!req_we)                                state_d = ST_LOAD;
          else if (req_funct3 == F3_W)                     state_d = ST_WR;
          else                                             state_d = ST_RMW_RD;
        end
      end
      ST_RMW_RD: begin
        merge_d = mem_rdata;
        state_d = ST_RMW_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
    end
  end

  // Outputs are decoded from registered state and latched fields only, so
  // nothing on the memory side follows req_* combinationally.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    mem_wen    = 1'b0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      ST_LOAD: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
      end
      ST_WR: begin
        mem_wen    = we_q;
        mem_wdata  = wdata_q;
        resp_valid = 1'b1;
      end
      ST_RMW_WR: begin
        mem_wen    = we_q;
        mem_wdata  = store_data;
        resp_valid = 1'b1;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word memory: combinational read, synchronous write.
  logic [31:0] mem [0:63];
  logic        addr_unused;
  assign addr_unused = ^{mem_addr[31:8], mem_addr[1:0]};
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int wen_count   = 0;
  int last_wen_cyc = -1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_wen === 1'b1) begin
      wen_count    = wen_count + 1;
      last_wen_cyc = cyc;
    end
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_resp: got err=%0b rdata=%h, required no response", resp_err, resp_rdata);
      end else begin
        e = sb.pop_front();
        $display("resp %s: err=%0b rdata=%h latency=%0d", e.name, resp_err, resp_rdata, cyc - e.t0);
        vectors++;
        if (resp_err !== e.err) begin
          miscompares++;
          $display("FAIL %s_err: got %0b, required %0b", e.name, resp_err, e.err);
        end
        vectors++;
        if (resp_rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL %s_rdata: got %h, required %h", e.name, resp_rdata, e.rdata);
        end
        vectors++;
        if ((cyc - e.t0) != e.lat) begin
          miscompares++;
          $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.t0, e.lat);
        end
      end
    end
  end

  // Drive one request once the unit is ready, queueing its expected result.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input string name, input logic err,
                      input logic [31:0] rdata, input int lat, output int t0);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s_ready_timeout: req_ready=%b after %0d cycles, required 1", name, req_ready, n);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    t0 = cyc;
    e.name = name; e.err = err; e.rdata = rdata; e.t0 = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued response has arrived.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s_drain_timeout: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_wen} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready/valid/err/wen=%b, required 1000",
               {req_ready, resp_valid, resp_err, mem_wen});
    end
    vectors++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_loads();
    int t;
    send(1'b1, 3'b010, 32'h40, 32'h8899AABB, "sw_init40", 1'b0, 32'h0, 1, t);
    send(1'b0, 3'b000, 32'h41, 32'h0, "lb_41",  1'b0, 32'hFFFFFFAA, 1, t);
    send(1'b0, 3'b100, 32'h43, 32'h0, "lbu_43", 1'b0, 32'h00000088, 1, t);
    send(1'b0, 3'b101, 32'h42, 32'h0, "lhu_42", 1'b0, 32'h00008899, 1, t);
    send(1'b0, 3'b001, 32'h40, 32'h0, "lh_40",  1'b0, 32'hFFFFAABB, 1, t);
    send(1'b0, 3'b000, 32'h40, 32'h0, "lb_40",  1'b0, 32'hFFFFFFBB, 1, t);
    send(1'b0, 3'b010, 32'h40, 32'h0, "lw_40",  1'b0, 32'h8899AABB, 1, t);
    drain("loads");
  endtask

  task automatic test_sb();
    int t0, t, w0;
    w0 = wen_count;
    send(1'b1, 3'b000, 32'h42, 32'h12345677, "sb_42", 1'b0, 32'h0, 2, t0);
    drain("sb");
    @(posedge clk); #1;
    vectors++;
    if (wen_count - w0 != 1) begin
      miscompares++;
      $display("FAIL sb_wen_count: got %0d, required 1", wen_count - w0);
    end
    vectors++;
    if (last_wen_cyc != t0 + 2) begin
      miscompares++;
      $display("FAIL sb_wen_cycle: got %0d, required %0d", last_wen_cyc, t0 + 2);
    end
    vectors++;
    if (mem[16] !== 32'h8877AABB) begin
      miscompares++;
      $display("FAIL sb_mem40: got %h, required 8877aabb", mem[16]);
    end
    send(1'b0, 3'b010, 32'h40, 32'h0, "lw_after_sb", 1'b0, 32'h8877AABB, 1, t);
    drain("sb_lw");
  endtask

  task automatic test_back_to_back();
    int t, t0, t1;
    send(1'b1, 3'b010, 32'h40, 32'h8899AABB, "sw_reinit40", 1'b0, 32'h0, 1, t);
    send(1'b1, 3'b001, 32'h40, 32'h0000CAFE, "sh_40", 1'b0, 32'h0, 2, t0);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_during_sh: got %b, required 0", req_ready);
    end
    send(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, "sw_44", 1'b0, 32'h0, 1, t1);
    vectors++;
    if (t1 != t0 + 3) begin
      miscompares++;
      $display("FAIL b2b_accept_cycle: got %0d, required %0d", t1, t0 + 3);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_during_sw: got %b, required 0", req_ready);
    end
    drain("b2b");
    @(posedge clk); #1;
    vectors++;
    if (mem[16] !== 32'h8899CAFE || mem[17] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL b2b_mem: got %h %h, required 8899cafe deadbeef", mem[16], mem[17]);
    end
  endtask

  task automatic test_errors();
    int t, w0;
    w0 = wen_count;
    send(1'b0, 3'b010, 32'h42, 32'h0,        "lw_mis_42", 1'b1, 32'h0, 1, t);
    send(1'b1, 3'b001, 32'h41, 32'h0000BEEF, "sh_mis_41", 1'b1, 32'h0, 1, t);
    send(1'b0, 3'b011, 32'h40, 32'h0,        "f3_011",    1'b1, 32'h0, 1, t);
    send(1'b1, 3'b100, 32'h40, 32'h000000EE, "sbu_illeg", 1'b1, 32'h0, 1, t);
    drain("errors");
    @(posedge clk); #1;
    vectors++;
    if (wen_count != w0) begin
      miscompares++;
      $display("FAIL err_wen: got %0d writes, required 0", wen_count - w0);
    end
    vectors++;
    if (mem[16] !== 32'h8899CAFE) begin
      miscompares++;
      $display("FAIL err_mem40: got %h, required 8899cafe", mem[16]);
    end
  endtask

  task automatic test_reset_abort();
    int t, w0, n;
    send(1'b1, 3'b010, 32'h50, 32'h11223344, "sw_init50", 1'b0, 32'h0, 1, t);
    drain("abort_init");
    w0 = wen_count;
    n = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h51; req_wdata = 32'h000000FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_wen !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_immediate: got wen=%b ready=%b, required 0 1", mem_wen, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || wen_count != w0) begin
      miscompares++;
      $display("FAIL abort_after: got ready=%b writes=%0d, required 1 0", req_ready, wen_count - w0);
    end
    @(posedge clk); #1;
    vectors++;
    if (mem[20] !== 32'h11223344) begin
      miscompares++;
      $display("FAIL abort_mem50: got %h, required 11223344", mem[20]);
    end
    $display("abort: sb 0x51 cancelled by reset");
  endtask

  task automatic test_hold_valid();
    exp_t e;
    int   t, t_sb, w0, n;
    send(1'b1, 3'b010, 32'h48, 32'hA1B2C3D4, "sw_init48", 1'b0, 32'h0, 1, t);
    drain("hold_init");
    w0 = wen_count;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h49; req_wdata = 32'h0000005E;
    t_sb = cyc;
    e.name = "sb_49_held"; e.err = 1'b0; e.rdata = 32'h0; e.t0 = cyc; e.lat = 2;
    sb.push_back(e);
    @(posedge clk); #1;
    // Second request stays presented while the store is in flight.
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h48; req_wdata = 32'h0;
    n = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (cyc != t_sb + 3) begin
      miscompares++;
      $display("FAIL hold_accept_cycle: got %0d, required %0d", cyc, t_sb + 3);
    end
    e.name = "lw_48_held"; e.err = 1'b0; e.rdata = 32'hA1B25ED4; e.t0 = cyc; e.lat = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("hold");
    vectors++;
    if (wen_count - w0 != 1) begin
      miscompares++;
      $display("FAIL hold_wen_count: got %0d, required 1", wen_count - w0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    test_reset();
    test_loads();
    test_sb();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    test_hold_valid();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the pipeline MEM stage and the word-wide data memory.
- The data memory has a combinational read, a synchronous word-only write and word addressing via addr>>2.
- This unit turns byte, halfword and word loads/stores into word accesses. Loads are extracted and sign/zero-extended; sub-word stores use read-modify-write.
- Misaligned and illegal requests are rejected.

Parameters:
- WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned or illegal access; valid with resp_valid.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- mem_wen  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  byte address to memory, low 2 bits forced 0.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  combinational memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All latched request registers and the merge register clear to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - Reset during RMW_RD/RMW_WR aborts the access; mem_wen is 0 immediately and no write occurs.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - On acceptance, we/funct3/addr/wdata are latched. All later outputs derive only from latched values and state.
- funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and goes to ERR.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Violation goes to ERR.
- FSM states:
  - IDLE: req_ready=1. On acceptance go to ERR, LOAD, WR (SW) or RMW_RD (SB/SH).
  - LOAD: mem_addr=latched addr & ~3. resp_rdata = extract(mem_rdata, addr[1:0], size), sign- or zero-extended. resp_valid=1. Next state IDLE.
  - WR: mem_wen=1, mem_wdata=latched wdata, resp_valid=1. Next state IDLE.
  - RMW_RD: mem_addr driven; mem_rdata captured into the merge register; no response. Next state RMW_WR.
  - RMW_WR: mem_wen=1. mem_wdata = merge register with lane(s) replaced (byte lane addr[1:0]; halfword lane addr[1]) by wdata[7:0] or wdata[15:0]. resp_valid=1. Next state IDLE.
  - ERR: resp_valid=1, resp_err=1, mem_wen=0. Next state IDLE.
- Latency, acceptance to resp_valid:
  - Load, SW and error: 1 cycle.
  - SB/SH: 2 cycles.
  - resp_valid is high exactly one cycle.
- Throughput: the next request is accepted in the cycle after resp_valid, since the unit returns to IDLE.
- Lane ordering is little-endian: byte 0 = bits [7:0].
- mem_wen is decoded from the registered state only; it never depends on req_* combinationally.
- Output defaults in every state not listed above: mem_wen=0, resp_valid=0, resp_err=0, resp_rdata=0. mem_addr holds the latched aligned address.

Decomposition:
- Package dmem_lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (IDLE, LOAD, WR, RMW_RD, RMW_WR, ERR).
  - Misalignment/illegal check function.
- Sub-module lsu_align (combinational): load extract + extend, and store lane merge. The FSM lives in dmem_lsu.

Test Plan:
- Memory word 0x40 = 0x8899AABB. LB addr 0x41 -> resp 1 cycle later, rdata 0xFFFFFFAA, err 0. LBU 0x43 -> 0x00000088. LHU 0x42 -> 0x00008899.
- SB addr 0x42 wdata 0x12345677 -> mem_wen high exactly once, 2 cycles after accept. Memory becomes 0x8877AABB; a following LW 0x40 returns it.
- SH addr 0x40 wdata 0xCAFE then SW addr 0x44 wdata 0xDEADBEEF, issued back-to-back -> memory 0x8899CAFE and 0xDEADBEEF; req_ready low during each operation.
- LW addr 0x42, SH addr 0x41, funct3 011 -> each gives resp_valid with resp_err=1 after 1 cycle; mem_wen stays 0; memory unchanged.
- Assert rst_n=0 during RMW_RD of an SB -> state IDLE, mem_wen never asserted, target word unchanged, req_ready=1 after release.
- Hold req_valid high during a multi-cycle op -> the second request is accepted only in the cycle after resp_valid; no request is dropped or duplicated.
